// File: rtl/rle_encoder.sv
// rle_encoder: turns zigzag-ordered quantized coefficients into JPEG entropy
// symbols (DC diff, AC run/size, ZRL, EOB). Classification writes at most one
// entry per coefficient into a symbol FIFO; the output side expands each
// entry's pending ZRL count into separate ZRL symbols ahead of its own symbol.
module rle_encoder #(
    parameter int DATA_WIDTH = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_kind,
    output logic [3:0]            out_run,
    output logic [3:0]            out_size,
    output logic [DATA_WIDTH:0]   out_amp,
    output logic                  out_last,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        KIND_DC  = 2'b00,
        KIND_AC  = 2'b01,
        KIND_ZRL = 2'b10,
        KIND_EOB = 2'b11
    } kind_t;

    typedef struct packed {
        logic [1:0]          zrl_cnt;
        logic [1:0]          kind;
        logic [3:0]          run;
        logic [3:0]          size;
        logic [DATA_WIDTH:0] amp;
        logic                last;
    } entry_t;

    // Magnitude category: bit length of |v|, 0 for v == 0.
    function automatic logic [3:0] bit_len(input logic [DATA_WIDTH:0] v);
        logic [DATA_WIDTH:0] m;
        m = v[DATA_WIDTH] ? -v : v;
        bit_len = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            if (m[i]) bit_len = 4'(i + 1);
        end
    endfunction

    // JPEG amplitude bits: v itself when positive, v-1 when negative, kept to sz bits.
    function automatic logic [DATA_WIDTH:0] amp_bits(input logic [DATA_WIDTH:0] v,
                                                     input logic [3:0] sz);
        logic [DATA_WIDTH:0] t;
        t = v[DATA_WIDTH] ? v - {{DATA_WIDTH{1'b0}}, 1'b1} : v;
        amp_bits = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            if (4'(i) < sz) amp_bits[i] = t[i];
        end
    endfunction

    logic [5:0]            idx;
    logic [3:0]            run;
    logic [1:0]            zrl_pend;
    logic [DATA_WIDTH-1:0] prev_dc;

    logic                  wr_req;
    logic                  wr_fire;
    logic                  full;
    entry_t                wr_entry;
    logic [DATA_WIDTH:0]   coef_ext;
    logic [DATA_WIDTH:0]   value;
    logic [3:0]            value_size;

    entry_t                mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           count;

    logic [1:0]            zrl_idx;
    logic                  out_final;
    logic                  advance;
    logic                  pop;
    logic [AW:0]           avail;
    logic [AW-1:0]         src_ptr;
    logic [1:0]            zrl_base;
    entry_t                src;

    // Build the FIFO entry for the incoming coefficient (DC diff, AC, or EOB).
    always_comb begin
        coef_ext   = {in_data[DATA_WIDTH-1], in_data};
        value      = in_sop ? coef_ext - {prev_dc[DATA_WIDTH-1], prev_dc} : coef_ext;
        value_size = bit_len(value);
        wr_req     = 1'b0;
        wr_entry   = '0;
        if (in_valid) begin
            if (in_sop) begin
                wr_req        = 1'b1;
                wr_entry.kind = KIND_DC;
                wr_entry.size = value_size;
                wr_entry.amp  = amp_bits(value, value_size);
            end else if (in_eop && in_data == '0) begin
                wr_req        = 1'b1;
                wr_entry.kind = KIND_EOB;
                wr_entry.last = 1'b1;
            end else if (in_data != '0) begin
                wr_req           = 1'b1;
                wr_entry.kind    = KIND_AC;
                wr_entry.zrl_cnt = zrl_pend;
                wr_entry.run     = run;
                wr_entry.size    = value_size;
                wr_entry.amp     = amp_bits(value, value_size);
                wr_entry.last    = in_eop;
            end
        end
    end

    // Track coefficient index, zero run, pending ZRLs, DC predictor and protocol errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            run       <= '0;
            zrl_pend  <= '0;
            prev_dc   <= '0;
            proto_err <= 1'b0;
        end else if (in_valid) begin
            if ((in_sop && idx != 6'd0) || (in_eop && idx != 6'd63))
                proto_err <= 1'b1;
            if (in_sop) begin
                prev_dc  <= in_data;
                run      <= '0;
                zrl_pend <= '0;
                idx      <= 6'd1;
            end else if (in_eop) begin
                run      <= '0;
                zrl_pend <= '0;
                idx      <= '0;
            end else if (in_data == '0) begin
                if (run == 4'd15) begin
                    run <= '0;
                    if (zrl_pend != 2'd3) zrl_pend <= zrl_pend + 2'd1;
                end else begin
                    run <= run + 4'd1;
                end
                idx <= idx + 6'd1;
            end else begin
                run      <= '0;
                zrl_pend <= '0;
                idx      <= idx + 6'd1;
            end
        end
    end

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_fire  = wr_req && !full;
    assign advance  = !out_valid || out_ready;
    assign pop      = out_valid && out_ready && out_final;
    assign avail    = count - {{AW{1'b0}}, pop};
    assign src_ptr  = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign zrl_base = pop ? 2'd0 : zrl_idx;
    assign src      = mem[src_ptr];

    // Symbol storage; entries are only written into free slots.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_entry;
    end

    // FIFO pointers and output register: expand ZRLs of the head, pop after its final symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            zrl_idx   <= '0;
            out_final <= 1'b0;
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (wr_req && full) overflow <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_fire) - (AW+1)'(pop);
            if (advance) begin
                if (avail != '0) begin
                    out_valid <= 1'b1;
                    if (zrl_base < src.zrl_cnt) begin
                        out_kind  <= KIND_ZRL;
                        out_run   <= 4'd15;
                        out_size  <= '0;
                        out_amp   <= '0;
                        out_last  <= 1'b0;
                        zrl_idx   <= zrl_base + 2'd1;
                        out_final <= 1'b0;
                    end else begin
                        out_kind  <= src.kind;
                        out_run   <= src.run;
                        out_size  <= src.size;
                        out_amp   <= src.amp;
                        out_last  <= src.last;
                        zrl_idx   <= '0;
                        out_final <= 1'b1;
                    end
                end else begin
                    out_valid <= 1'b0;
                    out_final <= 1'b0;
                    zrl_idx   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: drives whole 8x8 coefficient blocks, predicts the symbol
// stream from the JPEG run-length rules, and compares every accepted symbol.
module tb_rle_encoder;

    localparam int DW = 10;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_sop;
    logic          in_eop;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_kind;
    logic [3:0]    out_run;
    logic [3:0]    out_size;
    logic [DW:0]   out_amp;
    logic          out_last;
    logic          overflow;
    logic          proto_err;

    rle_encoder #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
        .out_last(out_last), .overflow(overflow), .proto_err(proto_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          sym_no = 0;
    int          ready_mode = 0;
    int          blk [64];
    int          model_prev_dc = 0;
    logic [21:0] exp_q [$];
    logic [21:0] tmp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input int kind, input int run, input int size,
                                       input int amp, input bit last);
        return {2'(kind), 4'(run), 4'(size), 11'(amp), last};
    endfunction

    // JPEG size/amplitude of a value, computed arithmetically.
    function automatic logic [21:0] mk_val(input int kind, input int run, input int v,
                                           input bit last);
        int m, sz, a;
        m  = (v < 0) ? -v : v;
        sz = 0;
        while (m > 0) begin
            sz++;
            m = m / 2;
        end
        a = (v >= 0) ? v : v + (1 << sz) - 1;
        return mk(kind, run, sz, a, last);
    endfunction

    // Reference model: symbols for blk[0..n-1], coefficient n-1 being the eop.
    task automatic build_expected(input int n);
        int zeros;
        tmp_q.delete();
        tmp_q.push_back(mk_val(0, 0, blk[0] - model_prev_dc, 1'b0));
        model_prev_dc = blk[0];
        zeros = 0;
        for (int i = 1; i < n; i++) begin
            if (blk[i] == 0) begin
                if (i == n - 1) tmp_q.push_back(mk(3, 0, 0, 0, 1'b1));
                else zeros++;
            end else begin
                for (int z = 0; z < zeros / 16; z++) tmp_q.push_back(mk(2, 15, 0, 0, 1'b0));
                tmp_q.push_back(mk_val(1, zeros % 16, blk[i], i == n - 1));
                zeros = 0;
            end
        end
    endtask

    task automatic push_expected(input int limit);
        for (int i = 0; i < tmp_q.size() && i < limit; i++) exp_q.push_back(tmp_q[i]);
    endtask

    // Drive coefficients 0..stop_at-1 of an n-coefficient block with random idle gaps.
    task automatic applyStimulus(input int n, input int gap_pct, input int stop_at);
        for (int i = 0; i < stop_at; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_sop   = 1'b0;
                in_eop   = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = DW'(blk[i]);
            in_sop   = (i == 0);
            in_eop   = (i == n - 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, got, want);
        end
    endtask

    // Wait (bounded) for all predicted symbols, then confirm none are left over.
    task automatic checkOutput(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: %0d symbols still outstanding, expected 0",
                     name, exp_q.size());
        end
    endtask

    // Downstream ready pattern: held low, held high, or random 90% high.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 99) < 90);
            endcase
        end
    end

    // Monitor: every accepted symbol is checked against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                logic [21:0] got, want;
                got = {out_kind, out_run, out_size, out_amp, out_last};
                checks++;
                sym_no++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected symbol#%0d: got kind=%0d run=%0d size=%0d amp=%h last=%0b, expected none",
                             sym_no, out_kind, out_run, out_size, out_amp, out_last);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        begin
                            errors++;
                            $display("[TB] FAIL symbol#%0d: got kind=%0d run=%0d size=%0d amp=%h last=%0b, expected kind=%0d run=%0d size=%0d amp=%h last=%0b",
                                     sym_no, got[21:20], got[19:16], got[15:12], got[11:1], got[0],
                                     want[21:20], want[19:16], want[15:12], want[11:1], want[0]);
                        end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_bit("reset overflow", overflow, 1'b0);
        check_bit("reset proto_err", proto_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 1;

        // DC=5 with all-zero AC, then DC=3 with all-zero AC.
        foreach (blk[i]) blk[i] = 0;
        blk[0] = 5;
        build_expected(64); push_expected(1000);
        applyStimulus(64, 0, 64);
        checkOutput("dc5_eob");
        blk[0] = 3;
        build_expected(64); push_expected(1000);
        applyStimulus(64, 0, 64);
        checkOutput("dc3_eob");

        // One ZRL then AC run 4; then three ZRLs and a last AC at index 63.
        blk[0] = 0; blk[21] = 1;
        build_expected(64); push_expected(1000);
        applyStimulus(64, 0, 64);
        checkOutput("zrl_ac");
        blk[21] = 0; blk[63] = -7;
        build_expected(64); push_expected(1000);
        applyStimulus(64, 0, 64);
        checkOutput("ac63_last");

        // Random sparse blocks with random idle gaps and random backpressure.
        ready_mode = 2;
        for (int b = 0; b < 20; b++) begin
            blk[0] = int'($urandom_range(0, 1023)) - 512;
            for (int i = 1; i < 64; i++)
                blk[i] = ($urandom_range(0, 99) < 70) ? 0 : int'($urandom_range(0, 1023)) - 512;
            build_expected(64); push_expected(1000);
            applyStimulus(64, 30, 64);
        end
        checkOutput("random");
        check_bit("no overflow under normal flow", overflow, 1'b0);
        check_bit("no proto_err on clean blocks", proto_err, 1'b0);

        // Dense block against a stalled output: only the first 16 entries survive.
        ready_mode = 0;
        blk[0] = 2;
        for (int i = 1; i < 64; i++) blk[i] = 1;
        build_expected(64); push_expected(16);
        applyStimulus(64, 0, 64);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_bit("overflow after stall", overflow, 1'b1);
        ready_mode = 1;
        checkOutput("overflow_contents");
        check_bit("overflow sticky", overflow, 1'b1);

        // Reset in the middle of a block: nothing stale, predictor restarts at 0.
        ready_mode = 0;
        blk[0] = 9;
        for (int i = 1; i < 64; i++) blk[i] = (i % 3 == 0) ? 4 : 0;
        applyStimulus(64, 0, 30);
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("mid-block reset out_valid", out_valid, 1'b0);
        check_bit("mid-block reset overflow", overflow, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_prev_dc = 0;
        ready_mode = 1;
        foreach (blk[i]) blk[i] = 0;
        blk[0] = 4;
        build_expected(64); push_expected(1000);
        applyStimulus(64, 0, 64);
        checkOutput("after_reset");

        // Short block with eop at index 2: still encoded, error flagged.
        blk[0] = 1; blk[1] = 2; blk[2] = 0;
        build_expected(3); push_expected(1000);
        applyStimulus(3, 0, 3);
        checkOutput("early_eop");
        check_bit("proto_err on early eop", proto_err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
